pc_ctrl: RTL
============

# pc_ctrl

Fetch-stage PC sequencer for the P7 pipeline. It owns the PC_F register and decides each cycle whether PC_F holds, steps by 4, or redirects to a branch, jump, jr, exception-handler or eret target. It runs a req/ack handshake with a variable-latency instruction memory and coordinates with the hazard unit's stall. It latches redirects that arrive while a fetch is outstanding so that none are lost.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, first fetch address
- HANDLER_PC, 32'h0000_4180, exception entry
- TEXT_LO / TEXT_HI, 32'h0000_3000 / 32'h0000_6ffc, legal fetch range (inclusive)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low
- stall_D  in  1  hazard unit freezes F/D
- nPcSel  in  3  000 seq, 001 beq-type, 010 j/jal, 011 jr/jalr; others illegal, treated as 000
- imm  in  26  D-stage instruction imm field
- PC_D  in  32  D-stage PC
- ra  in  32  forwarded rs value for jr
- req  in  1  CP0 exception/interrupt request
- eret  in  1  eret in D
- EPC  in  32  CP0 EPC (eret target, used as given)
- if_ack  in  1  IM data valid for PC_F this cycle
- PC_F  out  32  current fetch address
- if_req  out  1  fetch request
- flush_D  out  1  clear F/D register next edge
- adel_F  out  1  PC_F misaligned or outside [TEXT_LO, TEXT_HI]

## Operation
- States: BOOT, FETCH, HOLD.
  - BOOT: one cycle after reset release; if_req=0.
  - FETCH: if_req=1, waiting for if_ack.
  - HOLD: word acked but stall_D=1; if_req=0.
- Targets:
  - br = PC_D+4+{sext(imm[15:0]),2'b00}
  - j = {PC_D[31:28],imm,2'b00}
  - jr = ra
  - All arithmetic is modulo 2^32.
- Redirect priority: req > eret > branch/jump (nPcSel≠0 and stall_D=0). Sequential step is PC_F+4.
- The D-stage branch/eret sees PC_F as its delay slot. A control redirect therefore applies after the delay-slot fetch completes; it never discards it.
- Pending register pend_vld/pend_pc:
  - A control redirect seen in FETCH without if_ack is captured into pend_pc.
  - On the later advance, PC_F ← pend_pc and pend_vld clears.
  - A newer control redirect while pend_vld=1 is impossible by construction. If it occurs anyway, it overwrites pend_pc.
- Advance condition: (FETCH & if_ack & !stall_D) or (HOLD & !stall_D).
  - On advance, PC_F ← pend_pc if pend_vld, else the current control redirect if any, else PC_F+4.
- req in any state:
  - PC_F ← HANDLER_PC, state → FETCH, pend_vld ← 0, flush_D=1 that cycle.
  - Overrides stall_D and any outstanding fetch. An acked word in the same cycle is discarded.
- eret (stall_D=0): handled as a control redirect to EPC, plus flush_D=1 once eret applies. eret has no delay slot.
- adel_F is combinational on PC_F and is reported only when if_req=1.

## Timing
- Reset values: PC_F=RESET_PC, state=BOOT, pend_vld=0, pend_pc=0, if_req=0, flush_D=0.
- Reset is asserted asynchronously. Release is sampled on the clk edge, then BOOT lasts one cycle.
- With zero-wait IM (if_ack the same cycle as if_req), PC_F steps every cycle.
- Redirect latency: a target becomes PC_F at the first advance edge, which is at least 1 edge after the redirect is observed.
- FETCH with if_ack & stall_D → HOLD. PC_F is held.
- HOLD & !stall_D → FETCH. PC_F advances on that edge.
- req and eret in the same cycle: req wins and eret is dropped. CP0 re-handles eret after the handler.
- Reset mid-fetch: the outstanding ack is ignored, since if_req=0 in BOOT.

## Structure
- Shared package mips_pkg holds:
  - NPC_SEQ/NPC_BR/NPC_J/NPC_JR encodings
  - RESET_PC, HANDLER_PC, TEXT_LO/TEXT_HI
  - state enum
- Sub-module npc_target: a combinational br/j/jr target mux. It is instantiated once, with no priority logic inside.

## Test plan
- Reset low for 3 cycles, then release, zero-wait IM → BOOT 1 cycle; PC_F sequence is 3000, 3004, 3008.
- PC_F=3008, beq in D with PC_D=3004, imm=0x0003, if_ack delayed 2 cycles → pend_pc=3014, PC_F held at 3008, then 3014 on ack.
- stall_D high 3 cycles during FETCH with ack → HOLD, PC_F stays 300c, advances to 3010 on release edge.
- req while if_ack=0 and pend_vld=1 → PC_F=4180 next edge, pend_vld=0, flush_D=1.
- eret with EPC=3020, req same cycle → PC_F=4180. In a later cycle eret alone → PC_F=3020, flush_D=1.
- jr with ra=3002 → PC_F=3002, adel_F=1 while if_req=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the P7 fetch stage: next-PC select codes, address map
// constants, fetch sequencer states and the fetch-address legality check.
package mips_pkg;

  localparam logic [2:0] NPC_SEQ = 3'b000;
  localparam logic [2:0] NPC_BR  = 3'b001;
  localparam logic [2:0] NPC_J   = 3'b010;
  localparam logic [2:0] NPC_JR  = 3'b011;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI    = 32'h0000_6ffc;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } pc_state_e;

  // Word-misaligned or outside the inclusive text window.
  function automatic logic addr_bad(input logic [31:0] addr,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Fetch-stage control bundle: D-stage redirect inputs, CP0 inputs and the
// instruction-memory req/ack handshake around PC_F.
interface pc_ctrl_if;

  logic        stall_D;
  logic [2:0]  nPcSel;
  logic [25:0] imm;
  logic [31:0] PC_D;
  logic [31:0] ra;
  logic        req;
  logic        eret;
  logic [31:0] EPC;
  logic        if_ack;
  logic [31:0] PC_F;
  logic        if_req;
  logic        flush_D;
  logic        adel_F;

  modport master (
    input  stall_D, nPcSel, imm, PC_D, ra, req, eret, EPC, if_ack,
    output PC_F, if_req, flush_D, adel_F
  );

  modport slave (
    output stall_D, nPcSel, imm, PC_D, ra, req, eret, EPC, if_ack,
    input  PC_F, if_req, flush_D, adel_F
  );

endinterface

// File: rtl/npc_target.sv
// Combinational branch / jump / jr target mux; priority between redirect
// sources is resolved by the caller.
module npc_target
  import mips_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [31:0] pc_d,
  input  logic [25:0] imm,
  input  logic [31:0] ra,
  output logic [31:0] tgt,
  output logic        tgt_vld
);

  // Target per select code; illegal codes behave as sequential.
  always_comb begin
    tgt     = 32'h0000_0000;
    tgt_vld = 1'b0;
    case (sel)
      NPC_BR: begin
        tgt     = pc_d + 32'd4 + {{14{imm[15]}}, imm[15:0], 2'b00};
        tgt_vld = 1'b1;
      end
      NPC_J: begin
        tgt     = {pc_d[31:28], imm, 2'b00};
        tgt_vld = 1'b1;
      end
      NPC_JR: begin
        tgt     = ra;
        tgt_vld = 1'b1;
      end
      default: begin
        tgt     = 32'h0000_0000;
        tgt_vld = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch-stage PC sequencer: owns PC_F, handshakes with a variable-latency IM and
// parks control redirects that arrive while the delay-slot fetch is outstanding.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
  parameter logic [31:0] HANDLER_PC = mips_pkg::HANDLER_PC,
  parameter logic [31:0] TEXT_LO    = mips_pkg::TEXT_LO,
  parameter logic [31:0] TEXT_HI    = mips_pkg::TEXT_HI
) (
  input logic       clk,
  input logic       reset,
  pc_ctrl_if.master bus
);

  import mips_pkg::*;

  pc_state_e   state_r;
  logic [31:0] pc_r;
  logic        pend_vld_r;
  logic [31:0] pend_pc_r;
  logic        pend_eret_r;
  logic        if_req_r;
  logic        flush_r;
  logic        boot_arm_r;

  logic [31:0] tgt_s;
  logic        tgt_vld_s;
  logic        ctl_vld_s;
  logic [31:0] ctl_tgt_s;
  logic [31:0] nxt_pc_s;
  logic        nxt_flush_s;

  npc_target u_npc_target (
    .sel     (bus.nPcSel),
    .pc_d    (bus.PC_D),
    .imm     (bus.imm),
    .ra      (bus.ra),
    .tgt     (tgt_s),
    .tgt_vld (tgt_vld_s)
  );

  // Control redirect of this cycle and the PC/flush to apply on an advance.
  always_comb begin
    ctl_vld_s   = 1'b0;
    ctl_tgt_s   = tgt_s;
    nxt_pc_s    = pc_r + 32'd4;
    nxt_flush_s = 1'b0;
    if (bus.stall_D) begin
      ctl_vld_s = 1'b0;
    end else begin
      ctl_vld_s = bus.eret | tgt_vld_s;
    end
    if (bus.eret) begin
      ctl_tgt_s = bus.EPC;
    end else begin
      ctl_tgt_s = tgt_s;
    end
    if (pend_vld_r) begin
      nxt_pc_s    = pend_pc_r;
      nxt_flush_s = pend_eret_r;
    end else if (ctl_vld_s) begin
      nxt_pc_s    = ctl_tgt_s;
      nxt_flush_s = bus.eret;
    end else begin
      nxt_pc_s    = pc_r + 32'd4;
      nxt_flush_s = 1'b0;
    end
  end

  // Sequencer FSM; boot_arm_r keeps BOOT for a full cycle after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_BOOT;
      pc_r        <= RESET_PC;
      pend_vld_r  <= 1'b0;
      pend_pc_r   <= 32'h0000_0000;
      pend_eret_r <= 1'b0;
      if_req_r    <= 1'b0;
      flush_r     <= 1'b0;
      boot_arm_r  <= 1'b0;
    end else if (bus.req) begin
      state_r     <= ST_FETCH;
      pc_r        <= HANDLER_PC;
      pend_vld_r  <= 1'b0;
      pend_eret_r <= 1'b0;
      if_req_r    <= 1'b1;
      flush_r     <= 1'b1;
      boot_arm_r  <= 1'b1;
    end else begin
      flush_r    <= 1'b0;
      boot_arm_r <= 1'b1;
      case (state_r)
        ST_BOOT: begin
          if (boot_arm_r) begin
            state_r  <= ST_FETCH;
            if_req_r <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (bus.if_ack && bus.stall_D) begin
            state_r  <= ST_HOLD;
            if_req_r <= 1'b0;
          end else if (bus.if_ack) begin
            pc_r       <= nxt_pc_s;
            pend_vld_r <= 1'b0;
            flush_r    <= nxt_flush_s;
          end else if (ctl_vld_s) begin
            // Delay slot still in flight: park the target until it lands.
            pend_vld_r  <= 1'b1;
            pend_pc_r   <= ctl_tgt_s;
            pend_eret_r <= bus.eret;
          end
        end
        ST_HOLD: begin
          if (!bus.stall_D) begin
            state_r    <= ST_FETCH;
            if_req_r   <= 1'b1;
            pc_r       <= nxt_pc_s;
            pend_vld_r <= 1'b0;
            flush_r    <= nxt_flush_s;
          end
        end
        default: begin
          state_r  <= ST_BOOT;
          if_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC_F    = pc_r;
  assign bus.if_req  = if_req_r;
  assign bus.flush_D = flush_r;
  assign bus.adel_F  = if_req_r & addr_bad(pc_r, TEXT_LO, TEXT_HI);

endmodule
